// File: rtl/l2_block_mem_pkg.sv
// Shared types for the L2 block memory: FSM state, default block type, index/offset width helpers.
package l2_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } l2_state_t;

  localparam int L2_BLOCKS = 4;

  typedef logic [L2_BLOCKS-1:0][31:0] l2_block_t;

  function automatic int l2_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Word-offset bits plus the two byte bits below the block index.
  function automatic int l2_off_w(input int blocks);
    return $clog2(blocks) + 2;
  endfunction

endpackage

// File: rtl/l2_block_mem_req_timer.sv
// Access latency counter for l2_block_mem: load, decrement, expire at 1, abort clears.
module l2_req_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  input  logic       i_abort,
  output logic       o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_expire = (r_cnt == 8'd1);

endmodule

// File: rtl/l2_block_mem.sv
// Block-granular single-ported backing store with fixed access latency below the L1 cache.
// Optional access counters (stat_reads/stat_writes) are built when L2_STATS_EN is defined.
module l2_block_mem
  import l2_types::*;
#(
  parameter int BLOCKS  = 4,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [BLOCKS-1:0][31:0] mem_write_block,
  output logic [BLOCKS-1:0][31:0] mem_read_block,
  output logic                   mem_miss,
`ifdef L2_STATS_EN
  output logic [31:0]            stat_reads,
  output logic [31:0]            stat_writes,
`endif
  output l2_state_t              dbg_state
);

  localparam int IDX_W = l2_idx_w(DEPTH);
  localparam int OFF_W = l2_off_w(BLOCKS);

  typedef logic [BLOCKS-1:0][31:0] blk_t;

  // Handshake: the requester holds mem_req high until it observes mem_miss=0 (the RESP
  // cycle); dropping mem_req while in WAIT aborts the access. Inputs are sampled only at acceptance.
  l2_state_t        r_state;
  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  blk_t             r_wdata;
  blk_t             r_rdata;
  blk_t             r_mem [DEPTH] = '{default: '0};
`ifdef L2_STATS_EN
  logic [31:0]      r_stat_reads;
  logic [31:0]      r_stat_writes;
`endif

  logic             w_start;
  logic             w_expire;
  logic             w_to_resp;
  logic             w_acc_we;
  logic [IDX_W-1:0] w_acc_idx;
  logic [IDX_W-1:0] w_in_idx;
  blk_t             w_acc_data;
  logic             w_commit;
  logic             w_unused_addr;

  assign w_in_idx      = mem_addr[IDX_W+OFF_W-1:OFF_W];
  assign w_unused_addr = ^{mem_addr[31:IDX_W+OFF_W], mem_addr[OFF_W-1:0]};

  assign w_start   = (r_state == IDLE) && mem_req;
  assign w_to_resp = (w_start && (LATENCY == 1)) ||
                     ((r_state == WAIT) && mem_req && w_expire);

  // With LATENCY==1 the array is accessed on the acceptance edge, before the latches fill.
  assign w_acc_we   = (r_state == IDLE) ? mem_we          : r_we;
  assign w_acc_idx  = (r_state == IDLE) ? w_in_idx        : r_idx;
  assign w_acc_data = (r_state == IDLE) ? mem_write_block : r_wdata;
  assign w_commit   = w_to_resp && w_acc_we && !reset;

  l2_req_timer u_timer (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_start),
    .i_load_val (8'(LATENCY - 1)),
    .i_dec      ((r_state == WAIT) && mem_req && !w_expire),
    .i_abort    ((r_state == WAIT) && !mem_req),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clock) begin
    if (w_commit) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef L2_STATS_EN
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_we    <= mem_we;
            r_idx   <= w_in_idx;
            r_wdata <= mem_write_block;
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!mem_req) begin
            r_state <= IDLE;
          end else if (w_expire) begin
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_to_resp && !w_acc_we) begin
        r_rdata <= r_mem[w_acc_idx];
      end
`ifdef L2_STATS_EN
      if (w_to_resp && !w_acc_we) r_stat_reads  <= r_stat_reads + 32'd1;
      if (w_to_resp &&  w_acc_we) r_stat_writes <= r_stat_writes + 32'd1;
`endif
    end
  end

  always_comb begin
    mem_miss = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE:    mem_miss = mem_req;
        WAIT:    mem_miss = 1'b1;
        default: mem_miss = 1'b0;
      endcase
    end
  end

  assign mem_read_block = r_rdata;
  assign dbg_state      = r_state;
`ifdef L2_STATS_EN
  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
`endif

endmodule

// File: tb/tb_l2_block_mem.sv
// Randomized scoreboard bench for l2_block_mem against an array-based block store model.
module tb_l2_block_mem;
  import l2_types::*;

  localparam int BLOCKS  = 4;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 3;

  typedef logic [BLOCKS-1:0][31:0] blk_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req = 1'b0;
  logic       mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  blk_t       mem_write_block = '0;
  blk_t       mem_read_block;
  logic       mem_miss;
  l2_state_t  dbg_state;
`ifdef L2_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
`endif

  l2_block_mem #(.BLOCKS(BLOCKS), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_write_block (mem_write_block),
    .mem_read_block  (mem_read_block),
    .mem_miss        (mem_miss),
`ifdef L2_STATS_EN
    .stat_reads      (stat_reads),
    .stat_writes     (stat_writes),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state and reference model ----------------
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [BLOCKS*32-1:0] exp_q[$];
  blk_t model [DEPTH];
  blk_t last_read = '0;
  int   model_reads  = 0;
  int   model_writes = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int blk_idx(input logic [31:0] a);
    return int'((a / 32'd16) % 32'(DEPTH));
  endfunction

  // ---------------- monitor ----------------
  int miss_run = 0;
  always @(negedge clock) begin
    if (reset) begin
      miss_run = 0;
    end else if (mem_miss) begin
      miss_run++;
    end else begin
      if (mem_req) begin
        chk("miss_cycles", 128'(miss_run), 128'(LATENCY));
        chk("resp_pending", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) chk("resp_block", mem_read_block, exp_q.pop_front());
      end
      miss_run = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic we, input logic [31:0] addr, input blk_t data, input bit keep);
    int idx = blk_idx(addr);
    int n;
    if (we) begin
      model[idx] = data;
      model_writes++;
      exp_q.push_back(last_read);
    end else begin
      last_read = model[idx];
      model_reads++;
      exp_q.push_back(model[idx]);
    end
    @(posedge clock); #1;
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = addr;
    mem_write_block = data;
    @(posedge clock); #1;
    mem_we = 1'($urandom_range(0, 1));
    mem_addr = $urandom;
    mem_write_block = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (n < 50) begin
      @(negedge clock);
      if (!mem_miss) break;
      n++;
    end
    chk("resp_timeout", 128'(n < 50), 128'(1));
    if (!keep) begin
      @(posedge clock); #1;
      mem_req = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  blk_t b11;
  blk_t rnd;
  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    b11 = {32'h44, 32'h33, 32'h22, 32'h11};

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_miss", 128'(mem_miss), 128'(0));
    chk("reset_rdata", mem_read_block, 128'(0));
    chk("reset_state", 128'(dbg_state), 128'(IDLE));
`ifdef L2_STATS_EN
    chk("reset_stat_reads", 128'(stat_reads), 128'(0));
    chk("reset_stat_writes", 128'(stat_writes), 128'(0));
`endif

    access(1'b1, 32'h0000_0040, b11, 1'b0);
    access(1'b0, 32'h0000_0048, '0, 1'b0);
    access(1'b0, 32'h0000_1040, '0, 1'b0);
    access(1'b0, 32'h0000_0080, '0, 1'b0);

    // Abort a write to 0x80 after one WAIT cycle.
    @(posedge clock); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_write_block = {4{32'hAA}};
    @(posedge clock); #1;
    @(posedge clock); #1;
    mem_req = 1'b0;
    @(negedge clock);
    chk("abort_wait_miss", 128'(mem_miss), 128'(1));
    @(negedge clock);
    chk("abort_idle_miss", 128'(mem_miss), 128'(0));
    chk("abort_state", 128'(dbg_state), 128'(IDLE));
    access(1'b0, 32'h0000_0080, '0, 1'b0);
`ifdef L2_STATS_EN
    chk("abort_stat_writes", 128'(stat_writes), 128'(model_writes));
`endif

    // Write-back then fill, separated by one idle cycle.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    access(1'b1, 32'h0000_0100, rnd, 1'b0);
    access(1'b0, 32'h0000_0200, '0, 1'b0);

    // Reset during the second miss cycle of a write to 0x140.
    @(posedge clock); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h140; mem_write_block = {4{32'h5A5A_5A5A}};
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("reset_forces_miss", 128'(mem_miss), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    mem_req = 1'b0;
    last_read = '0;
    model_reads = 0;
    model_writes = 0;
    @(negedge clock);
    chk("midreset_state", 128'(dbg_state), 128'(IDLE));
    chk("midreset_rdata", mem_read_block, 128'(0));
    access(1'b0, 32'h0000_0140, '0, 1'b0);

    // Randomized traffic over 16 aliased block indices, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [31:0] addr;
      bit          keep;
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFF_F00F) | (32'($urandom_range(0, 15)) << 4);
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      keep = (i < 39) && ($urandom_range(0, 1) == 1);
      access(we, addr, rnd, keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    repeat (5) @(posedge clock);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
`ifdef L2_STATS_EN
    chk("final_stat_reads", 128'(stat_reads), 128'(model_reads));
    chk("final_stat_writes", 128'(stat_writes), 128'(model_writes));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_block_mem.md
# l2_block_mem

Block-granular, single-ported backing memory that sits directly below the L1 cache and services its `mem_req` / `mem_we` / `mem_addr` / `mem_miss` handshake. It models a lower-level store with a fixed, parameterised access latency. It holds `mem_miss` high while an access is in flight, then returns or commits a whole block of `BLOCKS` words. It serves as the L2/main memory in simulation and as the synthesizable backing store for FPGA builds.

## Interface
- `BLOCKS`, 4: 32-bit words per block; must match the cache's `BLOCKS`; power of two.
- `DEPTH`, 256: number of blocks stored; power of two.
- `LATENCY`, 3: cycles `mem_miss` stays high per access; legal range 1..255.
- `clock  in  1`: the single clock; all state changes on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `mem_req  in  1`: access request from the cache.
- `mem_we  in  1`: 1 = write block, 0 = read block; sampled at request acceptance.
- `mem_addr  in  32`: byte address, sampled at request acceptance.
- `mem_write_block  in  BLOCKS×32`: write data, sampled at request acceptance.
- `mem_read_block  out  BLOCKS×32`: read data, valid in the RESP cycle.
- `mem_miss  out  1`: 1 = access in flight, not complete.
- `stat_reads`, `stat_writes`  out  32 each: present only with `L2_STATS_EN`.

## Operation
- Block index is `mem_addr[$clog2(DEPTH)+$clog2(BLOCKS)+1 : $clog2(BLOCKS)+2]`.
  - Word-offset and byte bits are ignored; the access is always the full block.
  - Upper address bits are ignored, so addresses alias modulo `DEPTH*BLOCKS*4` bytes.
- The storage array is not reset. It is zero at simulation time 0.
- The FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `mem_miss = mem_req`.
  - On `mem_req=1`: latch the address, `mem_we` and write data, and load `cnt <= LATENCY-1`.
  - Next state is RESP if `LATENCY==1`, otherwise WAIT.
- **WAIT**
  - `mem_miss = 1`.
  - If `mem_req=0`, abort: go to IDLE and commit no write.
  - Otherwise, if `cnt==1`, go to RESP; else decrement `cnt`.
- **Array access** happens on the edge that enters RESP:
  - A write commits the latched block at the latched index.
  - A read loads the `mem_read_block` register from the array.
- **RESP**
  - `mem_miss = 0`. `mem_read_block` holds the read data; it is unchanged after a write.
  - Next state is always IDLE. A `mem_req` still high in the following IDLE cycle is treated as a new request.
- After RESP, `mem_read_block` holds its value until the next read completes.
- The requester keeps `mem_req` high until it sees `mem_miss=0`. A write-back followed by a fill is two separate requests; each pays the full `LATENCY`.

## Timing
- Reset values: state IDLE, `cnt` 0, `mem_read_block` 0, stats 0.
- `mem_miss` is forced to 0 while `reset=1`.
- A request first seen in cycle t behaves as follows:
  - `mem_miss=1` in cycles t .. t+LATENCY-1.
  - `mem_miss=0` with data valid in cycle t+LATENCY.
- Minimum spacing between request starts is LATENCY+1 cycles.
- `mem_miss` is combinational from `mem_req` in IDLE only; in WAIT and RESP it is a registered-state decode.
- Reset asserted in WAIT or RESP: the FSM returns to IDLE and no pending write commits. A write already committed on the RESP entry edge is kept.
- `mem_addr`, `mem_we` and `mem_write_block` changing after acceptance are ignored.

## Configuration
- `L2_STATS_EN` defined:
  - `stat_reads` increments on each completed read (RESP entry with we=0).
  - `stat_writes` increments on each completed write.
  - Aborted accesses are not counted. Counters wrap at 2^32.
- `L2_STATS_EN` undefined: the `stat_*` ports and counters are absent; behaviour is otherwise identical.

## Structure
- A shared package `l2_types` holds:
  - the state enum `l2_state_t` (IDLE, WAIT, RESP);
  - `L2_IDX_W` / `L2_OFF_W` derivation helpers;
  - the block type `l2_block_t`, defined as `logic [BLOCKS-1:0][31:0]`.
- One sub-module, `l2_req_timer`: load / decrement / expire counter with an abort input, used by the FSM.

## Test plan
Bench uses `BLOCKS=4`, `DEPTH=256`, `LATENCY=3`.
- Reset high for 2 cycles, then low with `mem_req=0` -> `mem_miss=0`, `mem_read_block=0`, `stat_*=0`.
- Write `0x0000_0040` with data {0x11,0x22,0x33,0x44} -> `mem_miss=1` for 3 cycles, then 0 for one cycle. A read of `0x0000_0048` then returns word0=0x11 and word3=0x44 after 3 miss cycles.
- Read `0x0000_1040` (alias of `0x40`) -> {0x11,0x22,0x33,0x44}. Read `0x0000_0080` (never written) -> all zeros.
- Write `0x80` with data all 0xAA; drop `mem_req` after 1 WAIT cycle -> IDLE next cycle. A later read of `0x80` returns 0 and `stat_writes` is unchanged.
- Write-back then fill: write `0x100`, wait for `mem_miss=0`, hold `mem_req` low 1 cycle, then read `0x200` -> the read sees 3 fresh miss cycles and returns 0.
- Reset asserted in the second miss cycle of a write to `0x140` -> `mem_miss=0` during reset; a subsequent read of `0x140` returns 0.
